// File: rtl/cosim_reset_handshake.sv
// Reset-handshake sequencer between the cosim driver and the cosim top.
// It holds the design in reset for HOLD_CYCLES cycles, then waits up to ACK_TIMEOUT
// cycles for dut_ready. In RUN it counts cycles and raises a sticky finish at the
// programmed limit. A missing acknowledge raises a sticky fault and re-holds the design
// in reset. Every output comes from a register, so no input reaches an output in the
// same cycle.
module cosim_reset_handshake #(
  parameter int unsigned HOLD_CYCLES = 4,
  parameter int unsigned ACK_TIMEOUT = 1024,
  parameter int unsigned CNT_WIDTH   = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 dut_ready,
  input  logic [31:0]          cycle_limit,
  output logic                 dut_rst,
  output logic                 running,
  output logic                 finish,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] cycle_count
);

  localparam int unsigned HoldW = $clog2(HOLD_CYCLES + 1);
  localparam int unsigned TmoW  = $clog2(ACK_TIMEOUT + 1);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(HOLD_CYCLES - 1);
  localparam logic [TmoW-1:0]  TmoLast  = TmoW'(ACK_TIMEOUT - 1);

  typedef enum logic [2:0] {
    StHold,
    StWaitAck,
    StRun,
    StDone,
    StFault
  } state_e;

  state_e               state_q;
  logic [HoldW-1:0]     hold_cnt_q;
  logic [TmoW-1:0]      tmo_cnt_q;
  logic [31:0]          limit_q;
  logic [CNT_WIDTH-1:0] cnt_q;
  logic                 dut_rst_q;
  logic                 running_q;
  logic                 finish_q;
  logic                 fault_q;

  logic [CNT_WIDTH-1:0] limit_ext;
  logic [CNT_WIDTH-1:0] cnt_inc;
  logic                 last_run;

  // Run-counter helpers: saturating increment and the "this edge is the last one" test.
  // Comparing against limit-1 (limit nonzero) avoids the wrap of cnt+1 at all-ones.
  always_comb begin
    limit_ext = CNT_WIDTH'(limit_q);
    cnt_inc   = (&cnt_q) ? cnt_q : cnt_q + CNT_WIDTH'(1);
    last_run  = (limit_q != 32'd0) && (cnt_q == limit_ext - CNT_WIDTH'(1));
  end

  // Sequencer FSM; outputs are registered alongside the state they belong to.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StHold;
      hold_cnt_q <= '0;
      tmo_cnt_q  <= '0;
      limit_q    <= '0;
      cnt_q      <= '0;
      dut_rst_q  <= 1'b1;
      running_q  <= 1'b0;
      finish_q   <= 1'b0;
      fault_q    <= 1'b0;
    end else begin
      unique case (state_q)
        StHold: begin
          if (hold_cnt_q == HoldLast) begin
            state_q   <= StWaitAck;
            tmo_cnt_q <= '0;
            dut_rst_q <= 1'b0;
          end else begin
            hold_cnt_q <= hold_cnt_q + HoldW'(1);
          end
        end
        StWaitAck: begin
          // An acknowledge on the timeout edge still counts as success.
          if (dut_ready) begin
            state_q   <= StRun;
            limit_q   <= cycle_limit;
            running_q <= 1'b1;
          end else if (tmo_cnt_q == TmoLast) begin
            state_q   <= StFault;
            fault_q   <= 1'b1;
            dut_rst_q <= 1'b1;
            cnt_q     <= '0;
          end else begin
            tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          end
        end
        StRun: begin
          cnt_q <= cnt_inc;
          if (last_run) begin
            state_q   <= StDone;
            running_q <= 1'b0;
            finish_q  <= 1'b1;
          end
        end
        StDone, StFault: begin
          // Terminal until rst.
        end
        default: begin
          // Unreachable encodings fall back to a fresh hold.
          state_q    <= StHold;
          hold_cnt_q <= '0;
          tmo_cnt_q  <= '0;
          cnt_q      <= '0;
          dut_rst_q  <= 1'b1;
          running_q  <= 1'b0;
          finish_q   <= 1'b0;
          fault_q    <= 1'b0;
        end
      endcase
    end
  end

  assign dut_rst     = dut_rst_q;
  assign running     = running_q;
  assign finish      = finish_q;
  assign fault       = fault_q;
  assign cycle_count = cnt_q;

endmodule
